seg7_reader: RTL and testbench



---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_lut.sv | 44 ++++
 rtl/seg7_reader.sv | 135 +++++++++++++
 tb/tb_seg7_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment reader: segment patterns (gfedcba),
// FSM state encoding and the decoded-pattern result type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef struct packed {
        logic [3:0] value;
        logic       is_valid;
        logic       is_blank;
        logic       is_invalid;
    } seg_dec_t;

endpackage

// File: rtl/seg7_lut.sv
// Combinational segment-pattern to hex-digit decode; anything outside the
// table and not blank is reported invalid.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   result
);

    // Pattern table lookup
    always_comb begin
        result.value      = 4'h0;
        result.is_valid   = 1'b1;
        result.is_blank   = 1'b0;
        result.is_invalid = 1'b0;
        case (pattern)
            SEG_0: result.value = 4'h0;
            SEG_1: result.value = 4'h1;
            SEG_2: result.value = 4'h2;
            SEG_3: result.value = 4'h3;
            SEG_4: result.value = 4'h4;
            SEG_5: result.value = 4'h5;
            SEG_6: result.value = 4'h6;
            SEG_7: result.value = 4'h7;
            SEG_8: result.value = 4'h8;
            SEG_9: result.value = 4'h9;
            SEG_A: result.value = 4'hA;
            SEG_B: result.value = 4'hB;
            SEG_C: result.value = 4'hC;
            SEG_D: result.value = 4'hD;
            SEG_E: result.value = 4'hE;
            SEG_F: result.value = 4'hF;
            SEG_BLANK: begin
                result.is_valid = 1'b0;
                result.is_blank = 1'b1;
            end
            default: begin
                result.is_valid   = 1'b0;
                result.is_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Samples segment lines, qualifies patterns over a stability window and
// decodes them. Optional sequence checker enabled by SEG_SEQ_CHECK_EN.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             digit_stb,
    output logic             blank,
    output logic             invalid,
    output logic [CNT_W-1:0] change_cnt,
    output logic             seq_err
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

    logic [6:0]        s_reg;
    logic [6:0]        cand;
    logic [6:0]        acc;
    logic [STAB_W-1:0] stab;
    logic [1:0]        state;
    logic              have_acc;
    logic              window_done;
    logic              accept;
    seg_dec_t          cand_dec;

    seg7_lut u_lut (
        .pattern (cand),
        .result  (cand_dec)
    );

    // Window closes on the edge where the count would reach STABLE_CYCLES,
    // giving STABLE_CYCLES+1 edges from seg_in change to strobe.
    always_comb begin
        window_done = (state == ST_SETTLE) && (s_reg == cand) &&
                      (stab == STAB_W'(STABLE_CYCLES - 1));
        accept      = window_done && (!have_acc || (cand != acc));
    end

    // Input sample, stability filter and state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg <= 7'h00;
            cand  <= 7'h00;
            stab  <= '0;
            state <= ST_IDLE;
        end else begin
            s_reg <= seg_in;
            if (s_reg != cand) begin
                cand  <= s_reg;
                stab  <= STAB_W'(1);
                state <= ST_SETTLE;
            end else if (state == ST_SETTLE) begin
                stab <= stab + STAB_W'(1);
                if (window_done) begin
                    state <= ST_LOCKED;
                end else begin
                    state <= ST_SETTLE;
                end
            end else begin
                state <= state;
            end
        end
    end

    // Accepted pattern and decoded outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= 7'h00;
            have_acc    <= 1'b0;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            digit_stb   <= 1'b0;
            blank       <= 1'b0;
            invalid     <= 1'b0;
            change_cnt  <= '0;
        end else begin
            digit_stb <= 1'b0;
            if (accept) begin
                acc         <= cand;
                have_acc    <= 1'b1;
                digit_valid <= cand_dec.is_valid;
                blank       <= cand_dec.is_blank;
                invalid     <= cand_dec.is_invalid;
                if (cand_dec.is_valid) begin
                    digit      <= cand_dec.value;
                    digit_stb  <= 1'b1;
                    change_cnt <= change_cnt + CNT_W'(1);
                end else begin
                    digit <= digit;
                end
            end else begin
                acc <= acc;
            end
        end
    end

`ifdef SEG_SEQ_CHECK_EN
    logic [3:0] ref_digit;
    logic       have_ref;
    logic [3:0] next_exp;

    always_comb begin
        next_exp = (ref_digit >= 4'd9) ? 4'd0 : (ref_digit + 4'd1);
    end

    // Valid digits must count 0..9 in order; blank/invalid leave the reference alone
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_digit <= 4'h0;
            have_ref  <= 1'b0;
            seq_err   <= 1'b0;
        end else if (accept && cand_dec.is_valid) begin
            ref_digit <= cand_dec.value;
            have_ref  <= 1'b1;
            if (have_ref && ((cand_dec.value > 4'd9) || (cand_dec.value != next_exp))) begin
                seq_err <= 1'b1;
            end else begin
                seq_err <= seq_err;
            end
        end else begin
            seq_err <= seq_err;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios then random
// patterns, compared against a run-length based reference model.
module tb_seg7_reader;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'h00;

    logic [3:0] digit, digit2;
    logic       digit_valid, digit_stb, blank, invalid, seq_err;
    logic       digit_valid2, digit_stb2, blank2, invalid2, seq_err2;
    logic [7:0] change_cnt;
    logic [1:0] change_cnt2;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .digit(digit),
        .digit_valid(digit_valid), .digit_stb(digit_stb), .blank(blank),
        .invalid(invalid), .change_cnt(change_cnt), .seq_err(seq_err)
    );

    seg7_reader #(.STABLE_CYCLES(STABLE), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .digit(digit2),
        .digit_valid(digit_valid2), .digit_stb(digit_stb2), .blank(blank2),
        .invalid(invalid2), .change_cnt(change_cnt2), .seq_err(seq_err2)
    );

    logic [6:0] table_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    logic [6:0] prev;
    int         run;
    bit         started, pend, m_have, m_have_ref;
    logic [6:0] pend_pat, m_acc;
    int         m_digit, m_cnt, m_ref;
    bit         m_valid, m_blank, m_inv, m_stb, m_seq;

    // 0..15 digit, 16 blank, -1 invalid
    function automatic int decode(input logic [6:0] p);
        if (p == 7'h00) return 16;
        for (int i = 0; i < 16; i++) if (table_pat[i] == p) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prev = 7'h00; run = 0; started = 0; pend = 0; pend_pat = 7'h00;
        m_have = 0; m_acc = 7'h00; m_have_ref = 0; m_ref = 0;
        m_digit = 0; m_cnt = 0; m_valid = 0; m_blank = 0; m_inv = 0; m_stb = 0; m_seq = 0;
    endtask

    task automatic model_edge(input logic [6:0] v);
        int d;
        m_stb = 0;
        if (pend && (!m_have || pend_pat != m_acc)) begin
            m_have = 1;
            m_acc  = pend_pat;
            d = decode(pend_pat);
            if (d == 16) begin
                m_blank = 1; m_valid = 0; m_inv = 0;
            end else if (d < 0) begin
                m_inv = 1; m_valid = 0; m_blank = 0;
            end else begin
                m_digit = d; m_valid = 1; m_blank = 0; m_inv = 0;
                m_stb = 1; m_cnt++;
                if (m_have_ref && d != (m_ref + 1) % 10) m_seq = 1;
                m_ref = d; m_have_ref = 1;
            end
        end
        pend = 0;
        if (v != prev) begin
            prev = v; run = 1; started = 1;
        end else if (started && run < STABLE) begin
            run++;
            pend = (run == STABLE);
            pend_pat = v;
        end
    endtask

    task automatic step(input logic [6:0] v, input logic r);
        seg_in = v;
        rst = r;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else model_edge(v);
        chk("digit", digit, m_digit);
        chk("digit_valid", digit_valid, m_valid);
        chk("digit_stb", digit_stb, m_stb);
        chk("blank", blank, m_blank);
        chk("invalid", invalid, m_inv);
        chk("change_cnt", change_cnt, m_cnt % 256);
        chk("change_cnt_w2", change_cnt2, m_cnt % 4);
`ifdef SEG_SEQ_CHECK_EN
        chk("seq_err", seq_err, m_seq);
`else
        chk("seq_err_off", seq_err, 1'b0);
`endif
    endtask

    task automatic hold(input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step(7'h00, 1'b1);

        // First digit: strobe on edge 5 after the change
        hold(7'h06, 4);
        chk("stb_not_yet", digit_stb, 1'b0);
        step(7'h06, 1'b0);
        chk("stb_edge5", digit_stb, 1'b1);
        chk("digit_1", digit, 4'h1);
        hold(7'h06, 3);

        // Short glitch returning to the locked pattern
        hold(7'h5B, 3);
        hold(7'h06, 10);
        chk("glitch_cnt", change_cnt, 8'd1);
        chk("glitch_digit", digit, 4'h1);

        // Invalid then blank keep the digit and count
        hold(7'h49, 10);
        chk("inv_flag", invalid, 1'b1);
        chk("inv_digit_hold", digit, 4'h1);
        hold(7'h00, 10);
        chk("blank_flag", blank, 1'b1);
        chk("blank_inv_clear", invalid, 1'b0);

        // Counting sequence 0..9,0 from reset
        step(7'h00, 1'b1);
        for (int i = 0; i < 10; i++) hold(table_pat[i], 20);
        hold(7'h3F, 20);
        chk("seq_cnt11", change_cnt, 8'd11);
        chk("seq_cnt_w2", change_cnt2, 2'd3);
`ifdef SEG_SEQ_CHECK_EN
        chk("seq_ok", seq_err, 1'b0);
        hold(7'h4F, 20);
        chk("seq_bad", seq_err, 1'b1);
        hold(7'h5B, 20);
        chk("seq_sticky", seq_err, 1'b1);
`else
        hold(7'h4F, 20);
`endif

        // Reset in the middle of a settle window
        hold(7'h66, 3);
        step(7'h66, 1'b1);
        chk("rst_digit", digit, 4'h0);
        chk("rst_cnt", change_cnt, 8'd0);
        hold(7'h66, 4);
        chk("rst_no_stb", digit_stb, 1'b0);
        step(7'h66, 1'b0);
        chk("rst_stb5", digit_stb, 1'b1);

        // Randomized patterns, holds and occasional resets
        for (int k = 0; k < 400; k++) begin
            int kind, len;
            logic [6:0] p;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 7);
            if (kind <= 6) p = table_pat[$urandom_range(0, 15)];
            else if (kind == 7) p = 7'h00;
            else p = 7'($urandom);
            if (kind == 9) begin
                for (int j = 0; j < (len % 2) + 1; j++) step(p, 1'b1);
            end else begin
                hold(p, len);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
